// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: opcodes and the bitwise operation shared by the logic unit pipeline.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND,
        OP_OR,
        OP_NAND,
        OP_NOR,
        OP_XOR,
        OP_XNOR,
        OP_NOT_A,
        OP_PASS_A
    } op_e;

    // Evaluated at 64 bits; callers truncate to their own operand width.
    function automatic logic [63:0] apply_op(op_e op, logic [63:0] a, logic [63:0] b);
        case (op)
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_NAND:  return ~(a & b);
            OP_NOR:   return ~(a | b);
            OP_XOR:   return a ^ b;
            OP_XNOR:  return ~(a ^ b);
            OP_NOT_A: return ~a;
            default:  return a;
        endcase
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/result valid-ready bundle for logic_unit_pipe.
interface logic_unit_pipe_if #(parameter int WIDTH = 8);
    import logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
    op_e              out_op;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, parity, out_op
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, parity, out_op
    );

endinterface

// File: rtl/logic_unit_stage.sv
// logic_unit_stage: one valid/ready register slice carrying a W-bit payload.
module logic_unit_stage #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Ready when empty or when the occupant leaves this same cycle.
    always_comb begin
        in_ready = !valid_q || out_ready;
        valid_d  = in_ready ? in_valid : valid_q;
        data_d   = (in_ready && in_valid) ? in_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined bitwise logic unit with valid/ready handshakes.
// Defining LOGIC_UNIT_PIPE_STATS_EN adds a saturating op_count output.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_pipe_if.slave bus
`ifdef LOGIC_UNIT_PIPE_STATS_EN
    ,
    output logic [31:0]      op_count
`endif
);

    // Payload layout: {op, parity, zero, result}
    localparam int             PW      = WIDTH + OP_W + 2;
    localparam logic [PW-1:0]  RST_VAL = PW'(1) << WIDTH;

    logic [WIDTH-1:0] res;
    logic [STAGES:0]  v;
    logic [STAGES:0]  r;
    logic [PW-1:0]    d [STAGES+1];

    assign res  = WIDTH'(apply_op(bus.op, 64'(bus.a), 64'(bus.b)));
    assign v[0] = bus.in_valid;
    assign d[0] = {bus.op, ^res, ~|res, res};
    assign r[STAGES] = bus.out_ready;
    assign bus.in_ready = r[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic_unit_stage #(.W(PW), .RST_VAL(RST_VAL)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (v[i]),
            .in_ready  (r[i]),
            .in_data   (d[i]),
            .out_valid (v[i+1]),
            .out_ready (r[i+1]),
            .out_data  (d[i+1])
        );
    end

    assign bus.out_valid = v[STAGES];
    assign bus.result    = d[STAGES][WIDTH-1:0];
    assign bus.zero      = d[STAGES][WIDTH];
    assign bus.parity    = d[STAGES][WIDTH+1];
    assign bus.out_op    = op_e'(d[STAGES][WIDTH+2 +: OP_W]);

`ifdef LOGIC_UNIT_PIPE_STATS_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (bus.out_valid && bus.out_ready && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_count = cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: table vectors, directed corner sequences and random traffic
// against a truth-table reference model; second instance covers WIDTH=1, STAGES=1.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(8)) bus ();
    logic_unit_pipe_if #(.WIDTH(1)) bus1 ();

`ifdef LOGIC_UNIT_PIPE_STATS_EN
    logic [31:0] op_count, op_count1;
`endif

    logic_unit_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef LOGIC_UNIT_PIPE_STATS_EN
        ,
        .op_count (op_count)
`endif
    );

    logic_unit_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
`ifdef LOGIC_UNIT_PIPE_STATS_EN
        ,
        .op_count (op_count1)
`endif
    );

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       p;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        op_e        op;
        logic [7:0] res;
        logic       z;
        logic       p;
    } vec_t;

    // Per-opcode truth table indexed by {a_bit, b_bit}
    logic [3:0] tt [8];
    exp_t       q [$];
    exp_t       pend;
    vec_t       tbl [11];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_out = 0;
    bit         chk_lat = 0;
    logic       exp1;

    function automatic exp_t model(logic [7:0] a, logic [7:0] b, op_e op);
        exp_t e;
        for (int i = 0; i < 8; i++) e.res[i] = tt[int'(op)][{a[i], b[i]}];
        e.z = (e.res == 8'h00);
        e.p = ($countones(e.res) % 2) == 1;
        e.cyc = 0;
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [7:0] a, logic [7:0] b, op_e op, logic ordy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.op        = op;
        bus.out_ready = ordy;
        pend          = model(a, b, op);
    endtask

    task automatic settle();
        #2;
    endtask

    // Score the handshakes about to complete at the coming rising edge, then move to the next falling edge.
    task automatic tick();
        exp_t e;
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_output: got result %h, expected no output", bus.result);
            end else begin
                e = q.pop_front();
                check("out_result", 64'(bus.result), 64'(e.res));
                check("out_zero", 64'(bus.zero), 64'(e.z));
                check("out_parity", 64'(bus.parity), 64'(e.p));
                if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            pend.cyc = cyc;
            q.push_back(pend);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && q.size() > 0; k++) step();
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tt = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};
        tbl[0]  = '{8'hF0, 8'h3C, OP_AND,    8'h30, 1'b0, 1'b0};
        tbl[1]  = '{8'hF0, 8'h3C, OP_OR,     8'hFC, 1'b0, 1'b0};
        tbl[2]  = '{8'hF0, 8'h3C, OP_NAND,   8'hCF, 1'b0, 1'b0};
        tbl[3]  = '{8'hF0, 8'h3C, OP_NOR,    8'h03, 1'b0, 1'b0};
        tbl[4]  = '{8'hF0, 8'h3C, OP_XOR,    8'hCC, 1'b0, 1'b0};
        tbl[5]  = '{8'hF0, 8'h3C, OP_XNOR,   8'h33, 1'b0, 1'b0};
        tbl[6]  = '{8'hF0, 8'h3C, OP_NOT_A,  8'h0F, 1'b0, 1'b0};
        tbl[7]  = '{8'hF0, 8'h3C, OP_PASS_A, 8'hF0, 1'b0, 1'b0};
        tbl[8]  = '{8'h55, 8'hAA, OP_AND,    8'h00, 1'b1, 1'b0};
        tbl[9]  = '{8'h55, 8'hAA, OP_OR,     8'hFF, 1'b0, 1'b0};
        tbl[10] = '{8'h01, 8'hAA, OP_PASS_A, 8'h01, 1'b0, 1'b1};

        drive(1'b0, 8'h00, 8'h00, OP_AND, 1'b1);
        bus1.in_valid = 1'b0;
        bus1.a = 1'b0;
        bus1.b = 1'b0;
        bus1.op = OP_AND;
        bus1.out_ready = 1'b1;

        // Power-on reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd1);
        check("rst_parity", 64'(bus.parity), 64'd0);
        check("rst_w1_out_valid", 64'(bus1.out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        // Table vectors back-to-back, fixed latency
        chk_lat = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1);
            pend.res = tbl[i].res;
            pend.z   = tbl[i].z;
            pend.p   = tbl[i].p;
            step();
        end
        drive(1'b0, 8'h00, 8'h00, OP_AND, 1'b1);
        drain();
        chk_lat = 1'b0;

        // Backpressure: continuous stream, consumer stalled for 5 cycles
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), op_e'(3'($urandom_range(0, 7))), 1'b0);
            settle();
            check("bp_in_ready", 64'(bus.in_ready), (k < 2) ? 64'd1 : 64'd0);
            if (k >= 2) begin
                check("bp_out_valid", 64'(bus.out_valid), 64'd1);
                check("bp_hold", 64'(bus.result), 64'(q[0].res));
            end
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, OP_AND, 1'b1);
        drain();

        // Random traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
                  op_e'(3'($urandom_range(0, 7))), $urandom_range(0, 9) < 6);
            step();
        end
        drive(1'b0, 8'h00, 8'h00, OP_AND, 1'b1);
        drain();
`ifdef LOGIC_UNIT_PIPE_STATS_EN
        check("op_count", 64'(op_count), 64'(n_out));
`endif

        // Reset while two items are in flight
        drive(1'b1, 8'($urandom), 8'($urandom), OP_XOR, 1'b0);
        step();
        drive(1'b1, 8'($urandom), 8'($urandom), OP_OR, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'h00, OP_AND, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_result", 64'(bus.result), 64'd0);
        check("mid_rst_zero", 64'(bus.zero), 64'd1);
        check("mid_rst_parity", 64'(bus.parity), 64'd0);
        q.delete();
        n_out = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 8'h00, 8'h00, OP_AND, 1'b1);
            settle();
            check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
            tick();
        end
`ifdef LOGIC_UNIT_PIPE_STATS_EN
        check("op_count_rst", 64'(op_count), 64'd0);
`endif

        // WIDTH=1, STAGES=1 exhaustive sweep with latency 1
        exp1 = 1'b0;
        for (int i = 0; i <= 32; i++) begin
            bus1.in_valid = (i < 32);
            bus1.a  = 1'(i >> 4);
            bus1.b  = 1'(i >> 3);
            bus1.op = op_e'(3'(i));
            #2;
            if (i == 0) begin
                check("w1_empty", 64'(bus1.out_valid), 64'd0);
            end else begin
                check("w1_valid", 64'(bus1.out_valid), 64'd1);
                check("w1_result", 64'(bus1.result), 64'(exp1));
                check("w1_zero", 64'(bus1.zero), 64'(!exp1));
                check("w1_parity", 64'(bus1.parity), 64'(exp1));
            end
            exp1 = tt[i & 7][{bus1.a, bus1.b}];
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have a parameter STAGES, default 2, giving the number of register stages (legal values 1 or 2).
REQ-003 The block SHALL have a port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have a port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have a port in_valid, input, 1 bit: operands and opcode are presented.
REQ-006 The block SHALL have a port in_ready, output, 1 bit: the block accepts the presented operands this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have a port op, input, 3 bits: an opcode of type logic_unit_pkg::op_e.
REQ-009 The block SHALL have a port out_valid, output, 1 bit: a result is presented.
REQ-010 The block SHALL have a port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-011 The block SHALL have a port result, output, WIDTH bits: the computed value.
REQ-012 The block SHALL have a port zero, output, 1 bit: result equals all-zeros.
REQ-013 The block SHALL have a port parity, output, 1 bit: XOR-reduction of result.

Function
REQ-014 The opcode mapping SHALL be: 0 AND a&b; 1 OR a|b; 2 NAND ~(a&b); 3 NOR ~(a|b); 4 XOR a^b; 5 XNOR ~(a^b); 6 NOT_A ~a; 7 PASS_A a (b ignored).
REQ-015 A transfer SHALL occur on a clock edge where both valid and ready are 1, on either the input side or the output side.
REQ-016 Result, zero, parity and op SHALL be captured together; zero and parity SHALL be computed from the full WIDTH-bit result.
REQ-017 Latency from input transfer to out_valid SHALL be exactly STAGES cycles when there is no backpressure.
REQ-018 Throughput SHALL be one transfer per cycle while out_ready=1.
REQ-019 Each stage SHALL be ready when it is empty or when its downstream stage is ready in the same cycle; in_ready SHALL equal the ready of the first stage.
REQ-020 Under backpressure (out_valid=1 and out_ready=0), result, zero, parity and out_valid SHALL hold stable until the transfer occurs.
REQ-021 On a full pipe with out_ready=0, in_ready SHALL be 0; no data SHALL be lost or duplicated.
REQ-022 Simultaneous drain and accept in the same cycle SHALL keep the pipe full with no bubble.
REQ-023 Operands presented with in_valid=0 SHALL have no effect on state.

Reset
REQ-024 Assertion of rst_n=0 SHALL asynchronously clear all stage valid bits: out_valid=0, result=0, zero=1, parity=0.
REQ-025 in_ready SHALL be 1 one cycle after rst_n deasserts.
REQ-026 A reset asserted while data is in flight SHALL discard that data; no out_valid SHALL appear for it after reset.
REQ-027 Reset deassertion SHALL be synchronised externally.

Configuration
REQ-028 When the macro LOGIC_UNIT_PIPE_STATS_EN is defined, the block SHALL add an output op_count (32 bits) that counts output transfers, saturates at 32'hFFFF_FFFF, and resets to 0.
REQ-029 When LOGIC_UNIT_PIPE_STATS_EN is not defined, the op_count port and its counter SHALL be absent.

Structure
REQ-030 Package logic_unit_pkg SHALL hold the op_e enum (OP_AND..OP_PASS_A), OP_W=3, and a function apply_op(op, a, b) sized by the caller.
REQ-031 Sub-module logic_unit_stage SHALL implement one generic valid/ready register slice, parameterised by payload width and instantiated STAGES times.

Verification
REQ-032 With WIDTH=8, a=F0, b=3C, ops 0..7 back-to-back, out_ready=1 -> results 30, FC, CF, 03, CC, 33, 0F, F0 appear on 8 consecutive cycles starting 2 cycles after the first input transfer.
REQ-033 Zero/parity check: a=55, b=AA, op=AND -> result=00, zero=1, parity=0; op=OR -> result=FF, zero=0, parity=0; op=PASS_A with a=01 -> parity=1.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles with a continuous input stream -> in_ready falls after 2 accepted items, result stays stable, and on release all items emerge in order with none lost.
REQ-035 Reset mid-flight: accept 2 items, then pulse rst_n low for 1 cycle -> out_valid=0 immediately, and no stale result appears afterwards.
REQ-036 With STAGES=1 and WIDTH=1, exhaustive a/b/op sweep -> every result matches the REQ-014 truth table with latency 1.
REQ-037 With LOGIC_UNIT_PIPE_STATS_EN defined, 10 output transfers (3 of them stalled) -> op_count=10.
